// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends start/8 data/odd parity/stop
// on device-generated clock falls, then checks the device ack. Lines are driven open-drain.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_ACK,
        S_WAIT_IDLE
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_prev_q;

    logic          sync_clk, sync_dat, fall, in_frame, timed;
    logic [2:0]    bidx;

    assign sync_clk = clk_sync_q[1];
    assign sync_dat = dat_sync_q[1];
    assign in_frame = state_q inside {S_START, S_DATA, S_PARITY, S_ACK};
    assign timed    = in_frame || (state_q == S_WAIT_IDLE);
    assign fall     = clk_prev_q & ~sync_clk & in_frame;
    assign bidx     = 3'(bit_q - 4'd1);

    assign tx_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);

    // Synchronisers reset high so an idle bus never looks like a falling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_data_in};
            clk_prev_q <= sync_clk;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            par_q   <= par_d;
            bit_q   <= bit_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        par_d       = par_q;
        bit_d       = bit_q;
        tmr_d       = tmr_q;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_done     = 1'b0;
        tx_error    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    data_d  = tx_data;
                    par_d   = ~^tx_data;
                    bit_d   = '0;
                    tmr_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                tmr_d      = tmr_q + CW'(1);
                if (tmr_q == INH_LAST) begin
                    ps2_data_oe = 1'b1;
                    tmr_d       = '0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                ps2_data_oe = 1'b1;
                if (fall) begin
                    bit_d   = bit_q + 4'd1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                ps2_data_oe = ~data_q[bidx];
                if (fall) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd8) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                ps2_data_oe = ~par_q;
                if (fall) begin
                    bit_d   = bit_q + 4'd1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                // Stop bit is the released line; the device pulls data low to ack on fall #11.
                if (fall) begin
                    bit_d = bit_q + 4'd1;
                    if (sync_dat) begin
                        tx_error = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (sync_clk && sync_dat) begin
                    tx_done = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inactivity watchdog; a device fall restarts it, expiry abandons the frame.
        if (timed) begin
            if (fall) begin
                tmr_d = '0;
            end else if (tmr_q == TO_LAST) begin
                ps2_clk_oe  = 1'b0;
                ps2_data_oe = 1'b0;
                tx_done     = 1'b0;
                tx_error    = 1'b1;
                state_d     = S_IDLE;
            end else begin
                tmr_d = tmr_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the DUT
// and the captured wire bits are compared with frames built from the byte by arithmetic.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 300;
    localparam int H   = 6;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, acc_cnt = 0;
    int acc_cyc = 0, done_cyc = 0, err_cyc = 0, start_cyc = 0, inh_cnt = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Wired-AND open-drain bus: either side can pull a line low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Frame as it should appear on the data line: start, LSB-first byte, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Passive monitor, sampled on the falling edge.
    initial begin
        logic prev_clk_oe, prev_pulse;
        prev_clk_oe = 1'b0;
        prev_pulse  = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            if (tx_valid && tx_ready && !reset) begin
                acc_cnt++;
                acc_cyc = cyc;
                inh_cnt = 0;
            end
            if (ps2_clk_oe) inh_cnt++;
            if (busy && prev_clk_oe && !ps2_clk_oe) start_cyc = cyc;
            if (tx_done || tx_error) begin
                chk("pulse_excl", 32'(tx_done & tx_error), 0);
                chk("pulse_lines", 32'({ps2_clk_oe, ps2_data_oe}), 0);
            end
            if (tx_done) begin done_cnt++; done_cyc = cyc; end
            if (tx_error) begin err_cnt++; err_cyc = cyc; end
            if (prev_pulse && !reset) chk("ready_after_pulse", 32'(tx_ready), 1);
            prev_pulse  = tx_done | tx_error;
            prev_clk_oe = ps2_clk_oe;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("accept_busy", 32'(busy), 1);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < INH + 20; i++) begin
            if (busy && !ps2_clk_oe && ps2_data_oe) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("start_seen", 32'(ok), 1);
    endtask

    task automatic wait_pulse(input int snap);
        for (int i = 0; i < TO + 50; i++) begin
            if (done_cnt + err_cnt != snap) break;
            tick();
        end
        chk("pulse_seen", 32'(done_cnt + err_cnt != snap), 1);
    endtask

    task automatic dev_clock(input int h);
        dev_clk = 1'b0;
        repeat (h) tick();
        dev_clk = 1'b1;
        repeat (h) tick();
    endtask

    // Device side: sample each bit on the rising clock, then ack (or not) on fall #11.
    task automatic dev_frame(input bit ack, input int h, output logic [10:0] fr);
        bit ok;
        int snap;
        fr   = '0;
        snap = done_cnt + err_cnt;
        wait_start(ok);
        if (!ok) return;
        repeat (3) tick();
        fr[0] = ps2_data_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clock(h);
            fr[k] = ps2_data_in;
        end
        if (ack) dev_data = 1'b0;
        repeat (2) tick();
        dev_clock(h);
        dev_data = 1'b1;
        wait_pulse(snap);
    endtask

    task automatic run_frame(input logic [7:0] b, input int h, input string tag);
        int d0, e0;
        logic [10:0] fr;
        d0 = done_cnt;
        e0 = err_cnt;
        send(b);
        dev_frame(1'b1, h, fr);
        chk({tag, "_frame"}, 32'(fr), 32'(model_frame(b)));
        chk({tag, "_done"}, 32'(done_cnt - d0), 1);
        chk({tag, "_noerr"}, 32'(err_cnt - e0), 0);
        chk({tag, "_inhibit"}, 32'(inh_cnt), INH);
        repeat (2) tick();
    endtask

    initial begin
        logic [10:0] fr;
        bit ok;
        int d0, e0, a0;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) tick();
        chk("rst_ready", 32'(tx_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_lines", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("rst_pulses", 32'({tx_done, tx_error}), 0);
        reset = 1'b0;
        repeat (3) tick();

        // 0xED LED command: bits 1,0,1,1,0,1,1,1 and parity 1.
        run_frame(8'hED, H, "ed");

        // Back-to-back with tx_valid held: second byte waits for the first tx_done.
        d0 = done_cnt;
        a0 = acc_cnt;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'h01;
        dev_frame(1'b1, H, fr);
        chk("b2b_frame0", 32'(fr), 32'(model_frame(8'h00)));
        chk("b2b_par0", 32'(fr[9]), 1);
        tick();
        tx_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_cnt - a0), 2);
        chk("b2b_accept_after_done", 32'(acc_cyc), 32'(done_cyc + 1));
        dev_frame(1'b1, H, fr);
        chk("b2b_frame1", 32'(fr), 32'(model_frame(8'h01)));
        chk("b2b_par1", 32'(fr[9]), 0);
        chk("b2b_done", 32'(done_cnt - d0), 2);
        repeat (2) tick();

        // Device withholds the ack.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h5A);
        dev_frame(1'b0, H, fr);
        chk("nack_err", 32'(err_cnt - e0), 1);
        chk("nack_nodone", 32'(done_cnt - d0), 0);
        chk("nack_ready", 32'(tx_ready), 1);
        chk("nack_lines", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        repeat (5) tick();

        // Device never clocks: watchdog fires TO cycles after START is entered.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h81);
        wait_start(ok);
        wait_pulse(done_cnt + err_cnt);
        chk("to_err", 32'(err_cnt - e0), 1);
        chk("to_nodone", 32'(done_cnt - d0), 0);
        chk("to_latency", 32'(err_cyc + 1 - start_cyc), TO);
        chk("to_lines", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        repeat (3) tick();

        for (int n = 0; n < 8; n++) begin
            run_frame(8'($urandom), int'($urandom_range(4, 8)), "rnd");
        end

        // Reset in the middle of the data bits.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hA5);
        wait_start(ok);
        repeat (3) tick();
        repeat (4) dev_clock(H);
        dev_clk = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("midrst_lines", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("midrst_busy", 32'(busy), 0);
        tick();
        reset   = 1'b0;
        dev_clk = 1'b1;
        repeat (4) tick();
        chk("midrst_nopulse", 32'((done_cnt - d0) + (err_cnt - e0)), 0);
        run_frame(8'hFF, H, "ff");

        // tx_valid pulses during INHIBIT and DATA must not disturb the frame.
        d0 = done_cnt;
        a0 = acc_cnt;
        send(8'h3C);
        fork
            dev_frame(1'b1, H, fr);
            begin
                repeat (5) tick();
                tx_data  = 8'hC3;
                tx_valid = 1'b1;
                tick();
                tx_valid = 1'b0;
                repeat (INH + 30) tick();
                tx_valid = 1'b1;
                repeat (2) tick();
                tx_valid = 1'b0;
            end
        join
        chk("ign_frame", 32'(fr), 32'(model_frame(8'h3C)));
        chk("ign_accepts", 32'(acc_cnt - a0), 1);
        chk("ign_done", 32'(done_cnt - d0), 1);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
